// File: rtl/vid_dma_pkg.sv
// Shared constants for the framebuffer copy engine: CSR map, CTRL/STAT bit
// positions and the sequencer state encoding.
package vid_dma_pkg;

  localparam logic [1:0] CSR_CTRL = 2'd0;
  localparam logic [1:0] CSR_SRC  = 2'd1;
  localparam logic [1:0] CSR_DST  = 2'd2;
  localparam logic [1:0] CSR_LEN  = 2'd3;

  localparam int C_START = 0;
  localparam int C_VSYNC = 1;
  localparam int C_ABORT = 2;
  localparam int C_IRQEN = 3;

  localparam int S_BUSY  = 0;
  localparam int S_DONE  = 1;
  localparam int S_VSYNC = 2;
  localparam int S_IRQEN = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RD   = 2'd2,
    WR   = 2'd3
  } dma_state_e;

endpackage

// File: rtl/vid_fb_dma_buf.sv
// Burst staging buffer: BURST x 32 flops, filled during reads and drained
// during writes; the write count doubles as the fill level.
module vid_fb_dma_buf #(
  parameter int BURST = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   push,
  input  logic [31:0]            wdata,
  input  logic                   pop,
  output logic [31:0]            rdata,
  output logic [$clog2(BURST):0] wr_cnt,
  output logic [$clog2(BURST):0] rd_cnt
);

  localparam int IW = $clog2(BURST);

  logic [BURST-1:0][31:0] mem;

  // Storage needs no reset; the counters decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_cnt[IW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (push) wr_cnt <= wr_cnt + 1'b1;
      if (pop)  rd_cnt <= rd_cnt + 1'b1;
    end
  end

  assign rdata = mem[rd_cnt[IW-1:0]];

endmodule

// File: rtl/vid_fb_dma.sv
// Wishbone bus-master copy engine feeding the framebuffer, with a 4-register
// CSR slave. Define VID_FB_DMA_IRQ_EN to add the done interrupt output.
module vid_fb_dma
  import vid_dma_pkg::*;
#(
  parameter int AW    = 22,
  parameter int BURST = 8,
  parameter int LW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    cs_addr,
  output logic [31:0]   cs_rdata,
  input  logic [31:0]   cs_wdata,
  input  logic          cs_we,
  input  logic          cs_cyc,
  output logic          cs_ack,
  output logic [AW-1:0] m_addr,
  input  logic [31:0]   m_rdata,
  output logic [31:0]   m_wdata,
  output logic [3:0]    m_wmsk,
  output logic          m_we,
  output logic          m_cyc,
  input  logic          m_ack,
  input  logic          vid_vbl
`ifdef VID_FB_DMA_IRQ_EN
  ,
  output logic          irq
`endif
);

  localparam int CW = $clog2(BURST) + 1;

  dma_state_e    state;
  logic [AW-1:0] src, dst;
  logic [LW-1:0] len_r;
  logic          done, vsync, abort_pend, vbl_q;
`ifdef VID_FB_DMA_IRQ_EN
  logic          irq_ena;
`endif

  logic          busy, wr, ctrl_wr, start_req, abort_req, abort_any;
  logic          buf_clr, buf_push, buf_pop, last_wr;
  logic [31:0]   buf_rdata, rdata_mux;
  logic [CW-1:0] buf_wr_cnt, buf_rd_cnt, rd_n;
  logic          unused_ok;

  assign busy      = (state != IDLE);
  assign wr        = cs_cyc & cs_ack & cs_we;
  assign ctrl_wr   = wr && (cs_addr == CSR_CTRL);
  assign abort_req = ctrl_wr & cs_wdata[C_ABORT];
  assign start_req = ctrl_wr & cs_wdata[C_START] & ~cs_wdata[C_ABORT] & ~busy;
  assign abort_any = abort_req | abort_pend;

  // Burst length is fixed for the whole RD phase since remaining only moves in WR.
  assign rd_n      = (len_r >= LW'(BURST)) ? CW'(BURST) : CW'(len_r);
  assign buf_push  = (state == RD) & m_cyc & m_ack;
  assign buf_pop   = (state == WR) & m_cyc & m_ack;
  assign last_wr   = (buf_rd_cnt + 1'b1 == buf_wr_cnt);
  assign buf_clr   = (state == IDLE) || (state == ARM) || (buf_pop && last_wr);

  assign m_wmsk    = 4'b0000;
  assign unused_ok = ^cs_wdata;

  vid_fb_dma_buf #(.BURST(BURST)) u_buf (
    .clk    (clk),
    .rst    (rst),
    .clr    (buf_clr),
    .push   (buf_push),
    .wdata  (m_rdata),
    .pop    (buf_pop),
    .rdata  (buf_rdata),
    .wr_cnt (buf_wr_cnt),
    .rd_cnt (buf_rd_cnt)
  );

  always_comb begin
    rdata_mux = '0;
    unique case (cs_addr)
      CSR_CTRL: begin
        rdata_mux[S_BUSY]  = busy;
        rdata_mux[S_DONE]  = done;
        rdata_mux[S_VSYNC] = vsync;
`ifdef VID_FB_DMA_IRQ_EN
        rdata_mux[S_IRQEN] = irq_ena;
`endif
        rdata_mux[31:16]   = 16'(len_r);
      end
      CSR_SRC: rdata_mux = 32'(src);
      CSR_DST: rdata_mux = 32'(dst);
      CSR_LEN: rdata_mux = 32'(len_r);
      default: rdata_mux = '0;
    endcase
  end

  assign cs_rdata = cs_ack ? rdata_mux : '0;

`ifdef VID_FB_DMA_IRQ_EN
  assign irq = done & irq_ena;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cs_ack     <= 1'b0;
      m_cyc      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      src        <= '0;
      dst        <= '0;
      len_r      <= '0;
      done       <= 1'b0;
      vsync      <= 1'b0;
      abort_pend <= 1'b0;
      vbl_q      <= 1'b0;
`ifdef VID_FB_DMA_IRQ_EN
      irq_ena    <= 1'b0;
`endif
    end else begin
      cs_ack <= cs_cyc & ~cs_ack;
      vbl_q  <= vid_vbl;

      if (ctrl_wr) begin
        done  <= 1'b0;
        vsync <= cs_wdata[C_VSYNC];
`ifdef VID_FB_DMA_IRQ_EN
        irq_ena <= cs_wdata[C_IRQEN];
`endif
      end

      if (wr && !busy) begin
        case (cs_addr)
          CSR_SRC: src   <= cs_wdata[AW-1:0];
          CSR_DST: dst   <= cs_wdata[AW-1:0];
          CSR_LEN: len_r <= cs_wdata[LW-1:0];
          default: ;
        endcase
      end

      unique case (state)
        IDLE: begin
          abort_pend <= 1'b0;
          if (start_req) begin
            if (len_r == '0)              done  <= 1'b1;
            else if (cs_wdata[C_VSYNC])   state <= ARM;
            else                          state <= RD;
          end
        end

        // Only an edge seen while armed counts, so a level already high waits.
        ARM: begin
          if (abort_req)                state <= IDLE;
          else if (vid_vbl && !vbl_q)   state <= RD;
        end

        RD: begin
          if (abort_req) abort_pend <= 1'b1;
          if (m_cyc) begin
            if (m_ack) begin
              m_cyc <= 1'b0;
              src   <= src + 1'b1;
              if (abort_pend)                      state <= IDLE;
              else if (buf_wr_cnt + 1'b1 == rd_n)  state <= WR;
            end
          end else if (abort_any) begin
            state <= IDLE;
          end else begin
            m_cyc  <= 1'b1;
            m_we   <= 1'b0;
            m_addr <= src;
          end
        end

        WR: begin
          if (abort_req) abort_pend <= 1'b1;
          if (m_cyc) begin
            if (m_ack) begin
              m_cyc <= 1'b0;
              m_we  <= 1'b0;
              dst   <= dst + 1'b1;
              len_r <= len_r - 1'b1;
              if (abort_pend) begin
                state <= IDLE;
              end else if (len_r == LW'(1)) begin
                state <= IDLE;
                done  <= 1'b1;
              end else if (last_wr) begin
                state <= RD;
              end
            end
          end else if (abort_any) begin
            state <= IDLE;
          end else begin
            m_cyc   <= 1'b1;
            m_we    <= 1'b1;
            m_addr  <= dst;
            m_wdata <= buf_rdata;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vid_fb_dma.sv
// Directed bench for vid_fb_dma: a bus-slave model with a transaction
// scoreboard built from the copy rules, plus CSR-level checks.
`timescale 1ns/1ps
module tb_vid_fb_dma;
  import vid_dma_pkg::*;

  localparam int AW = 22, BURST = 8, LW = 16;

  logic          clk = 1'b0, rst = 1'b1;
  logic [1:0]    cs_addr = '0;
  logic [31:0]   cs_rdata, cs_wdata = '0;
  logic          cs_we = 1'b0, cs_cyc = 1'b0, cs_ack;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_rdata, m_wdata;
  logic [3:0]    m_wmsk;
  logic          m_we, m_cyc, m_ack;
  logic          vid_vbl = 1'b0;
`ifdef VID_FB_DMA_IRQ_EN
  logic          irq;
`endif

  always #5 clk = ~clk;

  vid_fb_dma #(.AW(AW), .BURST(BURST), .LW(LW)) dut (
    .clk(clk), .rst(rst),
    .cs_addr(cs_addr), .cs_rdata(cs_rdata), .cs_wdata(cs_wdata),
    .cs_we(cs_we), .cs_cyc(cs_cyc), .cs_ack(cs_ack),
    .m_addr(m_addr), .m_rdata(m_rdata), .m_wdata(m_wdata), .m_wmsk(m_wmsk),
    .m_we(m_we), .m_cyc(m_cyc), .m_ack(m_ack),
    .vid_vbl(vid_vbl)
`ifdef VID_FB_DMA_IRQ_EN
    , .irq(irq)
`endif
  );

  typedef struct { logic we; logic [AW-1:0] addr; logic [31:0] data; } xact_t;
  xact_t         expq[$];
  logic [31:0]   wmem [int];
  int            nvec = 0, nerr = 0, nacks = 0, ws = 0;
  logic          cyc_seen = 1'b0;
  logic [AW-1:0] last_waddr = '0;

  function automatic logic [31:0] fdat(logic [AW-1:0] a);
    return 32'hC0DE_0000 ^ 32'(a);
  endfunction

  // Expected bus traffic: bursts of min(BURST, remaining) reads then writes.
  function automatic void plan(logic [AW-1:0] s, logic [AW-1:0] d, int len);
    int rem = len;
    while (rem > 0) begin
      int n = (rem > BURST) ? BURST : rem;
      for (int i = 0; i < n; i++) expq.push_back('{1'b0, s + AW'(i), 32'h0});
      for (int i = 0; i < n; i++) expq.push_back('{1'b1, d + AW'(i), fdat(s + AW'(i))});
      s = s + AW'(n);
      d = d + AW'(n);
      rem -= n;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Slave responder and per-cycle compare process.
  initial begin
    logic          pc;
    logic [AW-1:0] pa;
    logic          pw;
    logic [31:0]   pd;
    int            wc;
    xact_t         e;
    pc = 1'b0; pa = '0; pw = 1'b0; pd = '0; wc = 0;
    m_ack = 1'b0; m_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (m_ack) chk("cyc_after_ack", 32'(m_cyc), 32'd0);
        if (pc && !m_ack && m_cyc) begin
          chk("hold_addr", 32'(m_addr), 32'(pa));
          chk("hold_we", 32'(m_we), 32'(pw));
          if (m_we) chk("hold_wdata", m_wdata, pd);
        end
        if (!cs_ack) chk("rdata_idle", cs_rdata, 32'd0);
        chk("wmsk", 32'(m_wmsk), 32'd0);
      end
      if (m_cyc) cyc_seen = 1'b1;
      pc = m_cyc; pa = m_addr; pw = m_we; pd = m_wdata;
      if (!rst && m_cyc && !m_ack) begin
        if (wc == ws) begin
          m_ack = 1'b1;
          wc = 0;
          nacks++;
          if (expq.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL unexpected_xact: addr %h we %0d, none expected", m_addr, m_we);
          end else begin
            e = expq.pop_front();
            chk("xact_we", 32'(m_we), 32'(e.we));
            chk("xact_addr", 32'(m_addr), 32'(e.addr));
            if (e.we) chk("xact_wdata", m_wdata, e.data);
          end
          if (m_we) begin
            wmem[int'(m_addr)] = m_wdata;
            last_waddr = m_addr;
          end else begin
            m_rdata = fdat(m_addr);
          end
        end else begin
          wc++;
          m_ack = 1'b0;
        end
      end else begin
        m_ack = 1'b0;
        wc = 0;
      end
    end
  end

  task automatic csr(input logic we, input logic [1:0] a, input logic [31:0] d,
                     output logic [31:0] r);
    @(posedge clk); #1;
    cs_cyc = 1'b1; cs_we = we; cs_addr = a; cs_wdata = d;
    @(posedge clk);
    @(negedge clk);
    chk("cs_ack", 32'(cs_ack), 32'd1);
    r = cs_rdata;
    @(posedge clk); #1;
    cs_cyc = 1'b0; cs_we = 1'b0;
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] r;
    csr(1'b1, a, d, r);
  endtask

  task automatic csr_chk(input string nm, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] r;
    csr(1'b0, a, 32'h0, r);
    chk(nm, r, exp);
  endtask

  task automatic wait_idle(input int maxit);
    logic [31:0] r;
    int k = 0;
    do begin
      csr(1'b0, CSR_CTRL, 32'h0, r);
      k++;
    end while (r[S_BUSY] && k < maxit);
    chk("idle_timeout", 32'(r[S_BUSY]), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    int k;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_cyc", 32'(m_cyc), 32'd0);
    chk("rst_m_we", 32'(m_we), 32'd0);
    chk("rst_cs_ack", 32'(cs_ack), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    csr_chk("rst_stat", CSR_CTRL, 32'h0);
    csr_chk("rst_src", CSR_SRC, 32'h0);
    csr_chk("rst_len", CSR_LEN, 32'h0);

    // 20-word copy with a zero-wait slave: bursts of 8, 8, 4.
    csr_wr(CSR_SRC, 32'h0000_1000);
    csr_wr(CSR_DST, 32'h0020_0000);
    csr_wr(CSR_LEN, 32'd20);
    plan(22'h1000, 22'h20_0000, 20);
    nacks = 0;
    csr_wr(CSR_CTRL, 32'h1);
    wait_idle(200);
    chk("t1_acks", 32'(nacks), 32'd40);
    chk("t1_last_dst", 32'(last_waddr), 32'h0020_0013);
    chk("t1_last_data", wmem[32'h0020_0013], 32'hC0DE_1013);
    chk("t1_drained", 32'(expq.size()), 32'd0);
    csr_chk("t1_stat", CSR_CTRL, 32'h0000_0002);
    csr_chk("t1_src", CSR_SRC, 32'h0000_1014);
    csr_chk("t1_dst", CSR_DST, 32'h0020_0014);
    csr_chk("t1_len", CSR_LEN, 32'h0);

    // Source address wraps modulo 2^AW.
    csr_wr(CSR_SRC, 32'h003F_FFFE);
    csr_wr(CSR_DST, 32'h0000_0100);
    csr_wr(CSR_LEN, 32'd4);
    plan(22'h3F_FFFE, 22'h100, 4);
    csr_wr(CSR_CTRL, 32'h1);
    wait_idle(100);
    chk("wrap_first", wmem[32'h100], 32'hC0E1_FFFE);
    chk("wrap_last", wmem[32'h103], 32'hC0DE_0001);
    chk("wrap_drained", 32'(expq.size()), 32'd0);
    csr_chk("wrap_src", CSR_SRC, 32'h0000_0002);

    // VSYNC start with vblank already high: needs a fresh rising edge.
    @(posedge clk); #1 vid_vbl = 1'b1;
    csr_wr(CSR_SRC, 32'h40);
    csr_wr(CSR_DST, 32'h80);
    csr_wr(CSR_LEN, 32'd3);
    plan(22'h40, 22'h80, 3);
    cyc_seen = 1'b0;
    csr_wr(CSR_CTRL, 32'h3);
    repeat (6) @(posedge clk);
    #1 vid_vbl = 1'b0;
    repeat (4) @(posedge clk);
    chk("arm_no_cyc", 32'(cyc_seen), 32'd0);
    csr_chk("arm_stat", CSR_CTRL, 32'h0003_0005);
    @(posedge clk); #1 vid_vbl = 1'b1;
    k = 0;
    while (k < 10) begin
      @(posedge clk); #2;
      k++;
      if (m_cyc) break;
    end
    chk("vbl_latency", 32'(k >= 1 && k <= 3), 32'd1);
    wait_idle(100);
    chk("vs_data", wmem[32'h82], 32'hC0DE_0042);
    chk("vs_drained", 32'(expq.size()), 32'd0);
    #1 vid_vbl = 1'b0;

    // LEN == 0: done without any bus cycle.
    cyc_seen = 1'b0;
    csr_wr(CSR_CTRL, 32'h9);
`ifdef VID_FB_DMA_IRQ_EN
    csr_chk("len0_stat", CSR_CTRL, 32'h0000_000A);
`else
    csr_chk("len0_stat", CSR_CTRL, 32'h0000_0002);
`endif
    repeat (4) @(posedge clk);
    chk("len0_no_cyc", 32'(cyc_seen), 32'd0);

    // ABORT while a 3-wait-state read is pending.
    ws = 3;
    csr_wr(CSR_SRC, 32'h500);
    csr_wr(CSR_DST, 32'h600);
    csr_wr(CSR_LEN, 32'd20);
    expq.push_back('{1'b0, 22'h500, 32'h0});
    nacks = 0;
    csr_wr(CSR_CTRL, 32'h1);
    k = 0;
    while (!m_cyc && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("abort_cyc_started", 32'(m_cyc), 32'd1);
    csr_wr(CSR_CTRL, 32'h4);
    repeat (8) @(posedge clk);
    chk("abort_acks", 32'(nacks), 32'd1);
    chk("abort_drained", 32'(expq.size()), 32'd0);
    csr_chk("abort_stat", CSR_CTRL, 32'h0014_0000);
    csr_chk("abort_src", CSR_SRC, 32'h0000_0501);

    // Busy-time SRC write is ignored; then reset in the middle of a write cycle.
    ws = 2;
    csr_wr(CSR_SRC, 32'h2000);
    csr_wr(CSR_DST, 32'h0030_0000);
    plan(22'h2000, 22'h30_0000, 20);
    csr_wr(CSR_CTRL, 32'h1);
    csr_wr(CSR_SRC, 32'hDEAD);
    csr(1'b0, CSR_SRC, 32'h0, r);
    chk("src_busy_ignored", 32'(r != 32'hDEAD && r >= 32'h2000 && r <= 32'h2014), 32'd1);
    k = 0;
    while (!(m_cyc && m_we) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("wr_reached", 32'(m_cyc && m_we), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_inflight", 32'(m_cyc), 32'd1);
    @(negedge clk);
    chk("rst_cyc_drop", 32'(m_cyc), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    expq.delete();
    ws = 0;
    csr_chk("post_rst_stat", CSR_CTRL, 32'h0);
    csr_chk("post_rst_src", CSR_SRC, 32'h0);
    csr_chk("post_rst_dst", CSR_DST, 32'h0);
    csr_chk("post_rst_len", CSR_LEN, 32'h0);

`ifdef VID_FB_DMA_IRQ_EN
    csr_wr(CSR_SRC, 32'h10);
    csr_wr(CSR_DST, 32'h20);
    csr_wr(CSR_LEN, 32'd1);
    plan(22'h10, 22'h20, 1);
    csr_wr(CSR_CTRL, 32'h9);
    wait_idle(50);
    chk("irq_set", 32'(irq), 32'd1);
    csr_wr(CSR_CTRL, 32'h8);
    chk("irq_clr", 32'(irq), 32'd0);
    csr_chk("irq_stat", CSR_CTRL, 32'h0000_0008);
`endif

    repeat (4) @(posedge clk);
    chk("final_drained", 32'(expq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
